// File: rtl/utf8_to_wcs_engine.sv
// utf8_to_wcs_engine: converts a UTF-8 byte string in memory into a
// NUL-terminated wide-char string (UTF-16 or UTF-32) over one Avalon-MM master.
// Ports: clock/reset; start/busy/done/stall call-return handshake;
//   src_addr/src_len, dst_addr/dst_len, errno_addr/EINVAL call arguments;
//   returndata = chars written (excl. terminator) or 0xFFFFFFFF on error;
//   avmm_0_rw_* shared read/write master (one read outstanding at most).
module utf8_to_wcs_engine #(
    parameter int ADDR_W  = 64,
    parameter int DATA_W  = 64,
    parameter int WCHAR_W = 16
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  start,
    output logic                  busy,
    output logic                  done,
    input  logic                  stall,
    input  logic [ADDR_W-1:0]     src_addr,
    input  logic [31:0]           src_len,
    input  logic [ADDR_W-1:0]     dst_addr,
    input  logic [31:0]           dst_len,
    input  logic [ADDR_W-1:0]     errno_addr,
    input  logic [31:0]           EINVAL,
    output logic [31:0]           returndata,
    output logic [ADDR_W-1:0]     avmm_0_rw_address,
    output logic [DATA_W/8-1:0]   avmm_0_rw_byteenable,
    output logic                  avmm_0_rw_read,
    output logic                  avmm_0_rw_write,
    output logic [DATA_W-1:0]     avmm_0_rw_writedata,
    input  logic [DATA_W-1:0]     avmm_0_rw_readdata,
    input  logic                  avmm_0_rw_readdatavalid,
    input  logic                  avmm_0_rw_waitrequest
);

    localparam int BYTES = DATA_W / 8;
    localparam int OFF_W = $clog2(BYTES);
    localparam int CB    = WCHAR_W / 8;
    localparam int CSH   = $clog2(CB);
    localparam int NW    = DATA_W / WCHAR_W;
    localparam int NE    = DATA_W / 32;

    typedef enum logic [3:0] {
        IDLE, CHECK, FETCH, RWAIT, DECODE,
        WR_LO, WR_HI, TERM, ERR, RET
    } state_t;

    state_t state, st_nxt;

    logic [ADDR_W-1:0] a_src, a_dst, a_err;
    logic [31:0]       a_slen, a_dlen, a_einval;
    logic [31:0]       upos, wpos;
    logic [20:0]       cp;
    logic [1:0]        need;
    logic [7:0]        lo, hi;
    logic [DATA_W-1:0] c_data;
    logic [ADDR_W-1:0] c_tag;
    logic              c_valid;

    logic [ADDR_W-1:0] src_ptr, src_word;
    logic [OFF_W-1:0]  src_off;
    logic [7:0]        cur_b;
    logic              c_hit, len_end, dst_full;
    logic [ADDR_W-1:0] wr_ptr, wr_word, err_word;
    logic [BYTES-1:0]  be_w, be_e;
    logic              pair_q, pair_fit;
    logic [19:0]       cp_off;
    logic [31:0]       wc32;
    logic [WCHAR_W-1:0] wch;

    logic              d_err, d_term, d_emit, d_pair;
    logic [20:0]       d_cp;
    logic [1:0]        d_need;
    logic [7:0]        d_lo, d_hi;

    assign src_ptr  = a_src + ADDR_W'(upos);
    assign src_word = {src_ptr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
    assign src_off  = src_ptr[OFF_W-1:0];
    assign cur_b    = c_data[{src_off, 3'b000} +: 8];
    assign c_hit    = c_valid && (c_tag == src_word);
    assign len_end  = !a_slen[31] && (upos == a_slen);
    assign dst_full = (wpos == a_dlen - 32'd1);

    assign wr_ptr   = a_dst + (ADDR_W'(wpos) << CSH);
    assign wr_word  = {wr_ptr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
    assign be_w     = BYTES'({CB{1'b1}}) << wr_ptr[OFF_W-1:0];
    assign err_word = {a_err[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
    assign be_e     = BYTES'(4'hF) << a_err[OFF_W-1:0];

    // Supplementary-plane chars become a surrogate pair only in UTF-16 mode
    assign pair_q   = (WCHAR_W == 16) && (cp >= 21'h10000);
    assign cp_off   = 20'(cp - 21'h10000);
    assign pair_fit = ({1'b0, wpos} + 33'd2) <= ({1'b0, a_dlen} - 33'd1);

    always_comb begin
        wc32 = 32'd0;
        if (state == WR_LO) begin
            if (pair_q)
                wc32 = 32'hD800 | {22'd0, cp_off[19:10]};
            else
                wc32 = {11'd0, cp};
        end else if (state == WR_HI) begin
            wc32 = 32'hDC00 | {22'd0, cp_off[9:0]};
        end
    end

    assign wch = WCHAR_W'(wc32);

    // Byte decoder; lo/hi carry the legal range for the next continuation
    always_comb begin
        d_err  = 1'b0;
        d_term = 1'b0;
        d_emit = 1'b0;
        d_cp   = cp;
        d_need = need;
        d_lo   = 8'h80;
        d_hi   = 8'hBF;
        if (need == 2'd0) begin
            if (cur_b == 8'h00 && a_slen[31]) begin
                d_term = 1'b1;
            end else if (cur_b < 8'h80) begin
                d_emit = 1'b1;
                d_cp   = {13'd0, cur_b};
            end else if (cur_b >= 8'hC2 && cur_b <= 8'hDF) begin
                d_cp   = {16'd0, cur_b[4:0]};
                d_need = 2'd1;
            end else if (cur_b >= 8'hE0 && cur_b <= 8'hEF) begin
                d_cp   = {17'd0, cur_b[3:0]};
                d_need = 2'd2;
                if (cur_b == 8'hE0) d_lo = 8'hA0;
                if (cur_b == 8'hED) d_hi = 8'h9F;
            end else if (cur_b >= 8'hF0 && cur_b <= 8'hF4) begin
                d_cp   = {18'd0, cur_b[2:0]};
                d_need = 2'd3;
                if (cur_b == 8'hF0) d_lo = 8'h90;
                if (cur_b == 8'hF4) d_hi = 8'h8F;
            end else begin
                d_err = 1'b1;
            end
        end else begin
            if (cur_b >= lo && cur_b <= hi) begin
                d_cp   = {cp[14:0], cur_b[5:0]};
                d_need = need - 2'd1;
                d_emit = (need == 2'd1);
            end else begin
                d_err = 1'b1;
            end
        end
    end

    assign d_pair = (WCHAR_W == 16) && (d_cp >= 21'h10000);

    always_ff @(posedge clock) begin
        if (reset) state <= IDLE;
        else       state <= st_nxt;
    end

    always_comb begin
        st_nxt               = state;
        busy                 = (state != IDLE);
        done                 = (state == RET);
        avmm_0_rw_address    = '0;
        avmm_0_rw_byteenable = '0;
        avmm_0_rw_read       = 1'b0;
        avmm_0_rw_write      = 1'b0;
        avmm_0_rw_writedata  = '0;
        case (state)
            IDLE: if (start) st_nxt = CHECK;
            CHECK: begin
                if (a_dst == '0 || a_src == '0 || $signed(a_dlen) < 1)
                    st_nxt = ERR;
                else
                    st_nxt = FETCH;
            end
            FETCH: begin
                if (len_end) begin
                    st_nxt = (need != 2'd0) ? ERR : TERM;
                end else if (dst_full && need == 2'd0) begin
                    st_nxt = TERM;
                end else if (c_hit) begin
                    st_nxt = DECODE;
                end else begin
                    avmm_0_rw_read       = 1'b1;
                    avmm_0_rw_address    = src_word;
                    avmm_0_rw_byteenable = '1;
                    if (!avmm_0_rw_waitrequest) st_nxt = RWAIT;
                end
            end
            RWAIT: if (avmm_0_rw_readdatavalid) st_nxt = DECODE;
            DECODE: begin
                if (d_err)
                    st_nxt = ERR;
                else if (d_term)
                    st_nxt = TERM;
                else if (d_emit)
                    st_nxt = (d_pair && !pair_fit) ? TERM : WR_LO;
                else
                    st_nxt = FETCH;
            end
            WR_LO, WR_HI, TERM: begin
                avmm_0_rw_write      = 1'b1;
                avmm_0_rw_address    = wr_word;
                avmm_0_rw_byteenable = be_w;
                avmm_0_rw_writedata  = {NW{wch}};
                if (!avmm_0_rw_waitrequest) begin
                    if (state == TERM)
                        st_nxt = RET;
                    else if (state == WR_LO && pair_q)
                        st_nxt = WR_HI;
                    else
                        st_nxt = FETCH;
                end
            end
            ERR: begin
                avmm_0_rw_write      = 1'b1;
                avmm_0_rw_address    = err_word;
                avmm_0_rw_byteenable = be_e;
                avmm_0_rw_writedata  = {NE{a_einval}};
                if (!avmm_0_rw_waitrequest) st_nxt = RET;
            end
            RET: if (!stall) st_nxt = IDLE;
            default: st_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            a_src      <= '0;
            a_dst      <= '0;
            a_err      <= '0;
            a_slen     <= '0;
            a_dlen     <= '0;
            a_einval   <= '0;
            upos       <= '0;
            wpos       <= '0;
            cp         <= '0;
            need       <= '0;
            lo         <= 8'h80;
            hi         <= 8'hBF;
            c_data     <= '0;
            c_tag      <= '0;
            c_valid    <= 1'b0;
            returndata <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        a_src    <= src_addr;
                        a_dst    <= dst_addr;
                        a_err    <= errno_addr;
                        a_slen   <= src_len;
                        a_dlen   <= dst_len;
                        a_einval <= EINVAL;
                    end
                end
                CHECK: begin
                    upos    <= '0;
                    wpos    <= '0;
                    cp      <= '0;
                    need    <= '0;
                    lo      <= 8'h80;
                    hi      <= 8'hBF;
                    // memory may have changed since the previous call
                    c_valid <= 1'b0;
                end
                RWAIT: begin
                    if (avmm_0_rw_readdatavalid) begin
                        c_data  <= avmm_0_rw_readdata;
                        c_tag   <= src_word;
                        c_valid <= 1'b1;
                    end
                end
                DECODE: begin
                    upos <= upos + 32'd1;
                    cp   <= d_cp;
                    need <= d_need;
                    lo   <= d_lo;
                    hi   <= d_hi;
                end
                WR_LO, WR_HI: begin
                    if (!avmm_0_rw_waitrequest) wpos <= wpos + 32'd1;
                end
                TERM: begin
                    if (!avmm_0_rw_waitrequest) returndata <= wpos;
                end
                ERR: begin
                    if (!avmm_0_rw_waitrequest) returndata <= '1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_utf8_to_wcs_engine.sv
// tb_utf8_to_wcs_engine: directed bench for utf8_to_wcs_engine (UTF-16 and
// UTF-32 instances sharing one memory/bus responder and a write scoreboard).
module tb_utf8_to_wcs_engine;

    localparam int DW = 64;
    localparam int NB = DW / 8;

    typedef struct packed {
        logic [63:0] addr;
        logic [7:0]  n;
        logic [31:0] val;
    } wr_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, start, stall, sel;
    logic [63:0] src_addr, dst_addr, errno_addr;
    logic [31:0] src_len, dst_len, einval;
    logic        rdv, wreq;
    logic [DW-1:0] rdata;

    logic        a_busy, a_done, a_rd, a_wr;
    logic [31:0] a_ret;
    logic [63:0] a_addr, a_wd;
    logic [7:0]  a_be;
    logic        b_busy, b_done, b_rd, b_wr;
    logic [31:0] b_ret;
    logic [63:0] b_addr, b_wd;
    logic [7:0]  b_be;

    logic        m_busy, m_done, m_rd, m_wr;
    logic [31:0] m_ret;
    logic [63:0] m_addr, m_wd;
    logic [7:0]  m_be;

    assign m_busy = sel ? b_busy : a_busy;
    assign m_done = sel ? b_done : a_done;
    assign m_rd   = sel ? b_rd   : a_rd;
    assign m_wr   = sel ? b_wr   : a_wr;
    assign m_ret  = sel ? b_ret  : a_ret;
    assign m_addr = sel ? b_addr : a_addr;
    assign m_wd   = sel ? b_wd   : a_wd;
    assign m_be   = sel ? b_be   : a_be;

    utf8_to_wcs_engine #(.ADDR_W(64), .DATA_W(DW), .WCHAR_W(16)) u16 (
        .clock(clk), .reset(rst), .start(start & ~sel),
        .busy(a_busy), .done(a_done), .stall(stall),
        .src_addr(src_addr), .src_len(src_len),
        .dst_addr(dst_addr), .dst_len(dst_len),
        .errno_addr(errno_addr), .EINVAL(einval), .returndata(a_ret),
        .avmm_0_rw_address(a_addr), .avmm_0_rw_byteenable(a_be),
        .avmm_0_rw_read(a_rd), .avmm_0_rw_write(a_wr),
        .avmm_0_rw_writedata(a_wd), .avmm_0_rw_readdata(rdata),
        .avmm_0_rw_readdatavalid(rdv & ~sel),
        .avmm_0_rw_waitrequest(wreq)
    );

    utf8_to_wcs_engine #(.ADDR_W(64), .DATA_W(DW), .WCHAR_W(32)) u32 (
        .clock(clk), .reset(rst), .start(start & sel),
        .busy(b_busy), .done(b_done), .stall(stall),
        .src_addr(src_addr), .src_len(src_len),
        .dst_addr(dst_addr), .dst_len(dst_len),
        .errno_addr(errno_addr), .EINVAL(einval), .returndata(b_ret),
        .avmm_0_rw_address(b_addr), .avmm_0_rw_byteenable(b_be),
        .avmm_0_rw_read(b_rd), .avmm_0_rw_write(b_wr),
        .avmm_0_rw_writedata(b_wd), .avmm_0_rw_readdata(rdata),
        .avmm_0_rw_readdatavalid(rdv & sel),
        .avmm_0_rw_waitrequest(wreq)
    );

    int  tests = 0;
    int  fails = 0;
    int  reads = 0;
    int  rd_delay = 0;
    int  last_reads = 0;
    bit  stress = 1'b0;
    wr_t exp_q[$];
    bit [7:0] mem [bit [63:0]];

    task automatic chk(input string tag, input logic [159:0] got,
                       input logic [159:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [DW-1:0] read_word(input logic [63:0] a);
        logic [DW-1:0] w;
        w = '0;
        for (int i = 0; i < NB; i++)
            if (mem.exists(a + 64'(i))) w[i*8 +: 8] = mem[a + 64'(i)];
        return w;
    endfunction

    function automatic wr_t decode_wr(input logic [63:0] a,
                                      input logic [7:0] be,
                                      input logic [63:0] wd);
        wr_t r;
        int  lane;
        int  n;
        lane = 0;
        n = 0;
        for (int i = NB - 1; i >= 0; i--) if (be[i]) lane = i;
        for (int i = 0; i < NB; i++) if (be[i]) n++;
        r.addr = a + 64'(lane);
        r.n    = 8'(n);
        r.val  = '0;
        for (int i = 0; i < n && i < 4; i++)
            r.val[i*8 +: 8] = wd[(lane + i)*8 +: 8];
        return r;
    endfunction

    // Bus responder: decides at each falling edge what the next rising edge
    // accepts, so it sees the request exactly as the DUT presents it.
    initial begin
        bit          rd_pend;
        int          rd_cnt;
        logic [63:0] rd_addr;
        bit          hold;
        logic [137:0] saved;
        wr_t         got, e;
        rd_pend = 0;
        rd_cnt  = 0;
        rd_addr = '0;
        hold    = 0;
        saved   = '0;
        wreq    = 1'b0;
        rdv     = 1'b0;
        rdata   = '0;
        forever begin
            @(negedge clk);
            rdv = 1'b0;
            if (rd_pend) begin
                if (rd_cnt == 0) begin
                    rdv = 1'b1;
                    rdata = read_word(rd_addr);
                    rd_pend = 0;
                end else begin
                    rd_cnt--;
                end
            end
            if (hold && !rst)
                chk("req held", {m_rd, m_wr, m_addr, m_be, m_wd}, saved);
            if (m_rd || m_wr)
                chk("rd/wr exclusive", m_rd & m_wr, 0);
            wreq = stress ? ($urandom_range(0, 2) == 0) : 1'b0;
            if (m_rd && !wreq) begin
                chk("one outstanding", rd_pend, 0);
                reads++;
                rd_pend = 1;
                rd_addr = m_addr;
                rd_cnt  = stress ? $urandom_range(0, 5) : rd_delay;
            end
            if (m_wr && !wreq) begin
                got = decode_wr(m_addr, m_be, m_wd);
                chk("write expected", exp_q.size() > 0, 1);
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    chk("write", got, e);
                end
            end
            hold  = (m_rd || m_wr) && wreq;
            saved = {m_rd, m_wr, m_addr, m_be, m_wd};
        end
    end

    task automatic load(input logic [63:0] base, input logic [63:0] v,
                        input int n);
        mem.delete();
        for (int i = 0; i < n; i++)
            mem[base + 64'(i)] = v[(n-1-i)*8 +: 8];
    endtask

    task automatic push_wr(input logic [63:0] a, input int n,
                           input logic [31:0] v);
        wr_t r;
        r.addr = a;
        r.n    = 8'(n);
        r.val  = v;
        exp_q.push_back(r);
    endtask

    task automatic call(input string tag, input bit s,
                        input logic [63:0] sa, input logic [31:0] sl,
                        input logic [63:0] da, input logic [31:0] dl,
                        input logic [31:0] ret_exp, input int stall_n,
                        input bit poke);
        int r0;
        bit seen;
        sel        = s;
        src_addr   = sa;
        src_len    = sl;
        dst_addr   = da;
        dst_len    = dl;
        errno_addr = 64'h3000;
        einval     = 32'd22;
        stall      = (stall_n > 0);
        r0         = reads;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk({tag, " busy"}, m_busy, 1);
        if (poke) begin
            @(negedge clk);
            start    = 1'b1;
            src_addr = 64'h5550;
            @(negedge clk);
            start    = 1'b0;
            src_addr = sa;
        end
        seen = 0;
        for (int c = 0; c < 3000 && !seen; c++) begin
            @(negedge clk);
            seen = m_done;
        end
        chk({tag, " done"}, seen, 1);
        for (int c = 0; c < stall_n; c++) begin
            @(negedge clk);
            chk({tag, " stall done"}, m_done, 1);
            chk({tag, " stall ret"}, m_ret, ret_exp);
        end
        chk({tag, " ret"}, m_ret, ret_exp);
        stall = 1'b0;
        @(negedge clk);
        chk({tag, " idle"}, {m_busy, m_done}, 0);
        chk({tag, " writes left"}, exp_q.size(), 0);
        exp_q.delete();
        last_reads = reads - r0;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int r0;
        rst = 1'b1; start = 1'b0; stall = 1'b0; sel = 1'b0;
        src_addr = '0; dst_addr = '0; errno_addr = '0;
        src_len = '0; dst_len = '0; einval = 32'd22;
        repeat (3) @(negedge clk);
        chk("reset outs a", {a_busy, a_done, a_rd, a_wr, a_ret}, 0);
        chk("reset outs b", {b_busy, b_done, b_rd, b_wr, b_ret}, 0);
        rst = 1'b0;

        load(64'h1000, 64'h486900, 3);
        push_wr(64'h2000, 2, 32'h48);
        push_wr(64'h2002, 2, 32'h69);
        push_wr(64'h2004, 2, 32'h0);
        call("hi nul", 0, 64'h1000, -1, 64'h2000, 8, 2, 0, 0);
        chk("hi nul reads", last_reads, 1);

        load(64'h1000, 64'hE282ACF09F9880, 7);
        push_wr(64'h2000, 2, 32'h20AC);
        push_wr(64'h2002, 2, 32'hD83D);
        push_wr(64'h2004, 2, 32'hDE00);
        push_wr(64'h2006, 2, 32'h0);
        call("utf16 pair", 0, 64'h1000, 7, 64'h2000, 8, 3, 0, 0);

        load(64'h1000, 64'hF09F9880, 4);
        push_wr(64'h2000, 4, 32'h1F600);
        push_wr(64'h2004, 4, 32'h0);
        call("utf32", 1, 64'h1000, 4, 64'h2000, 8, 1, 0, 0);

        load(64'h1000, 64'hC080, 2);
        push_wr(64'h3000, 4, 32'd22);
        call("overlong", 0, 64'h1000, 2, 64'h2000, 8, 32'hFFFFFFFF, 0, 0);

        load(64'h1000, 64'hEDA080, 3);
        push_wr(64'h3000, 4, 32'd22);
        call("surrogate", 0, 64'h1000, 3, 64'h2000, 8, 32'hFFFFFFFF, 0, 0);

        load(64'h1000, 64'hE282, 2);
        push_wr(64'h3000, 4, 32'd22);
        call("truncated", 0, 64'h1000, 2, 64'h2000, 8, 32'hFFFFFFFF, 0, 0);

        load(64'h1000, 64'h61626364, 4);
        push_wr(64'h2000, 2, 32'h61);
        push_wr(64'h2002, 2, 32'h62);
        push_wr(64'h2004, 2, 32'h0);
        call("dst cap", 0, 64'h1000, 4, 64'h2000, 3, 2, 0, 0);

        load(64'h1000, 64'hF09F9880, 4);
        push_wr(64'h2000, 2, 32'h0);
        call("pair no fit", 0, 64'h1000, 4, 64'h2000, 2, 0, 0, 0);

        load(64'h1000, 64'h41, 1);
        push_wr(64'h3000, 4, 32'd22);
        call("null dst", 0, 64'h1000, 1, 64'h0, 8, 32'hFFFFFFFF, 0, 0);

        stress = 1'b1;
        load(64'h1005, 64'hE282ACF09F9880, 7);
        push_wr(64'h2006, 2, 32'h20AC);
        push_wr(64'h2008, 2, 32'hD83D);
        push_wr(64'h200A, 2, 32'hDE00);
        push_wr(64'h200C, 2, 32'h0);
        call("stress", 0, 64'h1005, 7, 64'h2006, 8, 3, 4, 1);
        chk("stress reads", last_reads, 2);
        stress = 1'b0;

        load(64'h1000, 64'h486900, 3);
        rd_delay   = 5;
        sel        = 1'b0;
        src_addr   = 64'h1000;
        src_len    = -1;
        dst_addr   = 64'h2000;
        dst_len    = 8;
        errno_addr = 64'h3000;
        r0         = reads;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int c = 0; c < 50; c++) begin
            @(negedge clk);
            #1;
            if (reads != r0) break;
        end
        chk("rst read seen", reads - r0, 1);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("rst outs", {m_busy, m_done, m_rd, m_wr, m_ret}, 0);
        rst = 1'b0;
        repeat (12) begin
            @(negedge clk);
            chk("rst quiet", {m_busy, m_rd, m_wr}, 0);
        end
        chk("rst no reads", reads - r0, 1);
        rd_delay = 0;

        push_wr(64'h2000, 2, 32'h48);
        push_wr(64'h2002, 2, 32'h69);
        push_wr(64'h2004, 2, 32'h0);
        call("after rst", 0, 64'h1000, -1, 64'h2000, 8, 2, 0, 0);
        chk("after rst reads", last_reads, 1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/utf8_to_wcs_engine.md
Name: utf8_to_wcs_engine

Overview:
- HLS-style task component that converts a UTF-8 byte string in memory into a NUL-terminated wide-character string in memory. It is the parametrised successor of the single-purpose UTF-8→wide conversion kernel.
- Uses one shared Avalon-MM read/write master, plus the start/busy/done/stall call-return handshake.
- Generalised over data-bus width and wide-char width (UTF-16 with surrogates, or UTF-32).
- Adds explicit-length or NUL-terminated input, destination-capacity truncation, strict rejection of invalid/overlong sequences, and an in-memory errno write.

Parameters:
ADDR_W, 64, byte-address width of avmm port
DATA_W, 64, avmm data width in bits; power of 2, 32..512; BYTES=DATA_W/8
WCHAR_W, 16, output char width; 16 = UTF-16 with surrogate pairs, 32 = UTF-32

Ports:
clock  in  1  clock; all logic rising-edge
reset  in  1  synchronous, active-high reset
start  in  1  call.valid; args sampled when start && !busy
busy  out  1  call.stall; high from accepted start until done consumed
done  out  1  return.valid
stall  in  1  return.stall; done/returndata held while high
src_addr  in  ADDR_W  UTF-8 source byte address
src_len  in  32  source length in bytes, signed; <0 = NUL-terminated
dst_addr  in  ADDR_W  destination address, WCHAR_W/8-aligned
dst_len  in  32  destination capacity in chars, including terminator
errno_addr  in  ADDR_W  address of 32-bit errno word
EINVAL  in  32  value written to errno on error
returndata  out  32  chars written excluding terminator, or 0xFFFFFFFF on error
avmm_0_rw_address  out  ADDR_W  word-aligned byte address
avmm_0_rw_byteenable  out  BYTES  lane enables
avmm_0_rw_read  out  1  read request
avmm_0_rw_write  out  1  write request
avmm_0_rw_writedata  out  DATA_W  write data, value replicated into addressed lanes
avmm_0_rw_readdata  in  DATA_W  read data
avmm_0_rw_readdatavalid  in  1  read response strobe
avmm_0_rw_waitrequest  in  1  slave stall; request held stable while high

Behaviour:
- Reset state: all outputs 0; FSM in IDLE; word cache invalid.
- FSM states: IDLE, CHECK, FETCH, RWAIT, DECODE, WR_LO, WR_HI, TERM, ERR, RET.
- IDLE:
  - start && !busy latches args; busy=1 next cycle; go to CHECK.
- CHECK:
  - dst_addr==0, src_addr==0, or dst_len<1 (signed) → ERR.
  - Otherwise clear upos, wpos, decode state → FETCH.
- FETCH / byte fetch:
  - Exit to TERM when src_len>=0 and upos==src_len.
  - Exit to TERM when wpos==dst_len-1.
  - If the byte's word matches the cached word (valid tag), go to DECODE the same cycle with no bus access.
  - Otherwise issue read with byteenable all-ones; hold until !waitrequest; then RWAIT.
  - RWAIT: on readdatavalid, load cache, set tag → DECODE.
  - Only one read outstanding at any time.
- DECODE, per byte:
  - Byte 0x00 when src_len<0 → TERM.
  - Leader ranges:
    - 00–7F: cp=b, complete.
    - C2–DF: need 1 continuation.
    - E0–EF: need 2 continuations.
    - F0–F4: need 3 continuations.
  - Continuation bytes must be 80–BF; each shifts 6 bits into cp.
  - Strict second-byte limits: E0 needs A0–BF; ED needs 80–9F (no surrogates); F0 needs 90–BF; F4 needs 80–8F.
  - Any other byte → ERR.
  - Source ends (length reached or NUL) mid-sequence → ERR.
  - upos increments on every consumed byte.
- Emit (on complete cp):
  - Writes use byteenable selecting the WCHAR_W/8 lanes at dst_addr+wpos*WCHAR_W/8.
  - WCHAR_W=32, or cp<0x10000: single write in WR_LO; wpos+=1.
  - WCHAR_W=16 and cp>=0x10000:
    - If wpos+2>dst_len-1 → TERM, pair not written.
    - Else WR_LO writes 0xD800|((cp-0x10000)>>10); WR_HI writes 0xDC00|(cp&0x3FF); wpos+=2.
  - Each write is held until !waitrequest; then FETCH.
- TERM:
  - Write char 0 at wpos.
  - RET with returndata=wpos.
- ERR:
  - Write 32-bit EINVAL to errno_addr.
  - RET with returndata=0xFFFFFFFF.
  - Destination contents already written are left as is; no terminator is guaranteed.
- RET:
  - done=1; holds while stall=1.
  - First cycle with stall=0 → IDLE; done=0 and busy=0 next cycle.
- Bus rules:
  - read and write never asserted together.
  - Address, byteenable and writedata constant while waitrequest=1.
- Reset mid-operation:
  - Abort immediately to IDLE; no further bus requests.
  - An in-flight readdatavalid arriving after reset is ignored.
- start while busy: ignored.

Test Plan:
- DATA_W=64, src "Hi\0" at 0x1000, src_len=-1, dst_len=8 → writes 0x0048, 0x0069, 0x0000 at 0x2000/2/4; returndata=2; exactly one read issued (cache hit on the 2nd and 3rd bytes).
- src E2 82 AC F0 9F 98 80, src_len=7, WCHAR_W=16 → writes 0x20AC, 0xD83D, 0xDE00, 0x0000; returndata=3.
- Same 4-byte input with WCHAR_W=32 → writes 0x0001F600, 0x00000000; returndata=1.
- src C0 80 (overlong), EINVAL=22 → 32-bit 22 written to errno_addr; returndata=0xFFFFFFFF.
  - src ED A0 80 → same error response.
  - src E2 82 with src_len=2 → same error response.
- src "abcd", src_len=4, dst_len=3 → writes 'a', 'b', 0; returndata=2.
  - F0 9F 98 80 with dst_len=2 → writes only 0; returndata=0.
- Bus stress:
  - Random waitrequest and readdatavalid delay 0–5 cycles, with stall=1 held 4 cycles at RET → identical memory image; done held with returndata stable.
  - reset asserted in RWAIT → outputs 0 next cycle; no writes follow.
